// File: rtl/spi_target.sv
// SPI target: oversamples SCLK/CS/MOSI in the clk domain and decodes a
// command/data frame against a 4-entry register file shared with a host port.
module spi_target #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            spi_mode,
    input  logic                  spi_sclk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [1:0]            host_addr,
    input  logic                  host_we,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  wr_strobe,
    output logic [1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  transfer_done,
    output logic                  frame_error
);
    localparam int                    CNT_W     = $clog2(2 * DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] STATUS    = DATA_WIDTH'(8'hA5);
    localparam logic [CNT_W-1:0]      CMD_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic                   miso_q, miso_d, cpol_q, cpol_d, cpha_q, cpha_d, w_q, w_d;
    logic [1:0]             addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d, host_rdata_q, host_rdata_d;
    logic                   wr_strobe_q, done_q, done_d, err_q, err_d;
    logic [3:0][DATA_WIDTH-1:0] mem_q, mem_d;

    logic                  sclk_s, cs_s, mosi_s, cs_fall_s, cs_rise_s;
    logic                  lead_s, trail_s, sample_s, shift_s, commit_s;
    logic [DATA_WIDTH-1:0] rx_shift_s;

    // Synchronizer shift and edge classification relative to the latched mode
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_fall_s   = cs_prev_q & ~cs_s;
        cs_rise_s   = ~cs_prev_q & cs_s;
        lead_s      = (sclk_s ^ sclk_prev_q) & (sclk_s ^ cpol_q);
        trail_s     = (sclk_s ^ sclk_prev_q) & ~(sclk_s ^ cpol_q);
        sample_s    = cpha_q ? trail_s : lead_s;
        shift_s     = cpha_q ? lead_s : trail_s;
        rx_shift_s  = {rx_q, mosi_s};
    end

    // Frame decoder: next state, shift registers and completion pulses
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        w_d       = w_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit_s  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (cs_rise_s) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            if (state_q == HOLD) begin
                done_d = 1'b1;
            end else begin
                err_d = (state_q != IDLE);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_d = CMD;
                        cpol_d  = spi_mode[1];
                        cpha_d  = spi_mode[0];
                        cnt_d   = '0;
                        // CPHA=0 presents the status MSB at once; CPHA=1 waits for the leading edge
                        miso_d  = STATUS[DATA_WIDTH-1];
                        tx_d    = spi_mode[0] ? STATUS : (STATUS << 1);
                    end else begin
                        miso_d = 1'b0;
                    end
                end
                CMD, DATA: begin
                    if (sample_s) begin
                        rx_d  = rx_shift_s[DATA_WIDTH-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((state_q == CMD) && (cnt_q == CMD_LAST)) begin
                            state_d = DATA;
                            w_d     = rx_shift_s[DATA_WIDTH-1];
                            addr_d  = rx_shift_s[1:0];
                            tx_d    = mem_q[rx_shift_s[1:0]];
                        end else if ((state_q == DATA) && (cnt_q == DATA_LAST)) begin
                            state_d  = HOLD;
                            miso_d   = 1'b0;
                            commit_s = w_q;
                            if (w_q) begin
                                wr_addr_d = addr_q;
                                wr_data_d = rx_shift_s;
                            end else begin
                                wr_addr_d = wr_addr_q;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else if (shift_s) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end else begin
                        tx_d = tx_q;
                    end
                end
                HOLD:    miso_d  = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Register file write port: an SPI commit overrides a host write to the same entry
    always_comb begin
        mem_d        = mem_q;
        host_rdata_d = mem_q[host_addr];
        if (host_we) begin
            mem_d[host_addr] = host_wdata;
        end else begin
            mem_d[host_addr] = mem_q[host_addr];
        end
        if (commit_s) begin
            mem_d[addr_q] = rx_shift_s;
        end else begin
            mem_d[addr_q] = mem_d[addr_q];
        end
    end

    // State and output registers; synchronizers reset to the idle bus levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            w_q          <= 1'b0;
            addr_q       <= 2'd0;
            wr_addr_q    <= 2'd0;
            wr_data_q    <= '0;
            wr_strobe_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            host_rdata_q <= '0;
            mem_q        <= '0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            w_q          <= w_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strobe_q  <= commit_s;
            done_q       <= done_d;
            err_q        <= err_d;
            host_rdata_q <= host_rdata_d;
            mem_q        <= mem_d;
        end
    end

    assign spi_miso      = miso_q;
    assign host_rdata    = host_rdata_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign transfer_done = done_q;
    assign frame_error   = err_q;
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-bangs SPI frames in all modes and compares the
// outputs each cycle with a frame-level model of the register file.
module tb_spi_target;
    localparam int SYNC_STAGES = 2;
    localparam int H           = SYNC_STAGES + 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic [1:0] spi_mode = 2'd0;
    logic       spi_sclk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0, spi_miso;
    logic [1:0] host_addr = 2'd0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = 8'd0, host_rdata;
    logic       wr_strobe, transfer_done, frame_error;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    spi_target #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .spi_mode(spi_mode), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .host_addr(host_addr), .host_we(host_we),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .transfer_done(transfer_done),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_strobe = 0, n_done = 0, n_err = 0;

    // pin-level events announced by the initiator, and frame decode info
    logic       ev_commit = 1'b0, ev_snap = 1'b0, ev_done = 1'b0, ev_err = 1'b0;
    logic       f_w = 1'b0;
    logic [1:0] f_addr = 2'd0;
    logic [7:0] f_data = 8'd0;
    logic       coll_en = 1'b0, coll_pend = 1'b0;
    logic [1:0] coll_addr = 2'd0;
    logic [7:0] coll_data = 8'd0;

    // model: pin events take effect SYNC_STAGES+1 clocks later
    logic [SYNC_STAGES-1:0] dc, dsn, dd, de;
    logic [7:0] m_mem [4];
    logic [7:0] m_rdata, m_wr_data, m_snap;
    logic [1:0] m_wr_addr;
    logic       m_strobe, m_done, m_err;
    int         m_cs_hi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dc <= '0; dsn <= '0; dd <= '0; de <= '0;
            for (int i = 0; i < 4; i++) m_mem[i] <= 8'd0;
            m_rdata <= 8'd0; m_wr_data <= 8'd0; m_snap <= 8'd0; m_wr_addr <= 2'd0;
            m_strobe <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_cs_hi <= 0;
        end else begin
            dc  <= {dc[SYNC_STAGES-2:0], ev_commit};
            dsn <= {dsn[SYNC_STAGES-2:0], ev_snap};
            dd  <= {dd[SYNC_STAGES-2:0], ev_done};
            de  <= {de[SYNC_STAGES-2:0], ev_err};
            m_strobe <= dc[SYNC_STAGES-1];
            m_done   <= dd[SYNC_STAGES-1];
            m_err    <= de[SYNC_STAGES-1];
            m_rdata  <= m_mem[host_addr];
            m_cs_hi  <= spi_cs ? ((m_cs_hi < 100) ? m_cs_hi + 1 : m_cs_hi) : 0;
            if (dsn[SYNC_STAGES-1]) m_snap <= m_mem[f_addr];
            if (host_we) m_mem[host_addr] <= host_wdata;
            if (dc[SYNC_STAGES-1]) begin
                m_mem[f_addr] <= f_data;
                m_wr_addr     <= f_addr;
                m_wr_data     <= f_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        check("wr_strobe", {31'd0, wr_strobe}, {31'd0, m_strobe});
        check("transfer_done", {31'd0, transfer_done}, {31'd0, m_done});
        check("frame_error", {31'd0, frame_error}, {31'd0, m_err});
        check("wr_addr", {30'd0, wr_addr}, {30'd0, m_wr_addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, m_wr_data});
        check("host_rdata", {24'd0, host_rdata}, {24'd0, m_rdata});
        if (m_cs_hi >= 4) check("miso_idle", {31'd0, spi_miso}, 32'd0);
        if (wr_strobe) n_strobe++;
        if (transfer_done) n_done++;
        if (frame_error) n_err++;
    endtask

    task automatic wait_half();
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ev_commit = 1'b0; ev_snap = 1'b0; ev_done = 1'b0; ev_err = 1'b0;
            end
            if (coll_pend && k == SYNC_STAGES) begin
                host_addr = coll_addr; host_wdata = coll_data; host_we = 1'b1;
            end
            if (coll_pend && k == SYNC_STAGES + 1) begin
                host_we = 1'b0; coll_pend = 1'b0;
            end
        end
    endtask

    task automatic mark_sample(input int idx);
        if (idx == 7) ev_snap = 1'b1;
        if (idx == 15) begin
            ev_commit = f_w;
            coll_pend = coll_en;
        end
    endtask

    task automatic spi_frame(input logic [1:0] mode, input logic [23:0] fbits, input int nbits,
                             input int abort_at, output logic [23:0] rx);
        logic cpol, cpha;
        cpol = mode[1]; cpha = mode[0]; rx = 24'd0;
        f_w = fbits[23]; f_addr = fbits[17:16]; f_data = fbits[15:8];
        @(negedge clk);
        spi_mode = mode; spi_sclk = cpol; spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
        spi_cs = 1'b0;
        if (!cpha) spi_mosi = fbits[23];
        wait_half();
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                spi_cs = 1'b1; spi_sclk = cpol; spi_mosi = 1'b0;
                repeat (6) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (!cpha) begin
                rx[23-i] = spi_miso; spi_sclk = ~cpol; mark_sample(i);
                wait_half();
                spi_sclk = cpol;
                if (i + 1 < nbits) spi_mosi = fbits[23-(i+1)];
                wait_half();
            end else begin
                spi_sclk = ~cpol; spi_mosi = fbits[23-i];
                wait_half();
                rx[23-i] = spi_miso; spi_sclk = cpol; mark_sample(i);
                wait_half();
            end
        end
        spi_cs = 1'b1;
        if (nbits >= 16) ev_done = 1'b1;
        else ev_err = 1'b1;
        wait_half();
        repeat (4) @(negedge clk);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk); host_we = 1'b0;
    endtask

    task automatic host_read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        @(negedge clk); host_addr = a;
        repeat (2) @(negedge clk);
        check(name, {24'd0, host_rdata}, {24'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rx;
        int s0, d0, e0;
        #1 rst = 1'b1;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_rdata", {24'd0, host_rdata}, 32'd0);
        check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_done", {30'd0, transfer_done, frame_error}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // mode 0 write 0x82, 0x3C
        s0 = n_strobe; d0 = n_done;
        spi_frame(2'd0, 24'h823C00, 16, -1, rx);
        check("m0_strobes", n_strobe - s0, 32'd1);
        check("m0_done", n_done - d0, 32'd1);
        check("m0_wr_addr", {30'd0, wr_addr}, 32'd2);
        check("m0_wr_data", {24'd0, wr_data}, 32'h3C);
        check("m0_miso_status", {24'd0, rx[23:16]}, 32'hA5);
        host_read_check("m0_mem2", 2'd2, 8'h3C);

        // reads in modes 1..3 of a host-preloaded entry
        host_write(2'd1, 8'h5A);
        for (int m = 1; m < 4; m++) begin
            s0 = n_strobe; d0 = n_done;
            spi_frame(m[1:0], 24'h010000, 16, -1, rx);
            check("rd_status", {24'd0, rx[23:16]}, 32'hA5);
            check("rd_data", {24'd0, rx[15:8]}, 32'h5A);
            check("rd_data_model", {24'd0, rx[15:8]}, {24'd0, m_snap});
            check("rd_no_strobe", n_strobe - s0, 32'd0);
            check("rd_done", n_done - d0, 32'd1);
        end

        // short frame: command 0x83 plus five data bits
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        spi_frame(2'd0, {8'h83, 5'b10110, 11'd0}, 13, -1, rx);
        check("short_err", n_err - e0, 32'd1);
        check("short_no_done", n_done - d0, 32'd0);
        check("short_no_strobe", n_strobe - s0, 32'd0);
        host_read_check("short_mem3", 2'd3, 8'h00);

        // collision with a host write to the same, then a different, entry
        coll_en = 1'b1; coll_addr = 2'd0; coll_data = 8'hFF;
        spi_frame(2'd0, 24'h801100, 16, -1, rx);
        host_read_check("coll_same_mem0", 2'd0, 8'h11);
        coll_addr = 2'd1;
        spi_frame(2'd0, 24'h801100, 16, -1, rx);
        coll_en = 1'b0;
        host_read_check("coll_diff_mem1", 2'd1, 8'hFF);
        host_read_check("coll_diff_mem0", 2'd0, 8'h11);

        // reset after bit 10 of a write frame
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        spi_frame(2'd0, 24'h82AB00, 16, 10, rx);
        check("abort_miso", {31'd0, spi_miso}, 32'd0);
        check("abort_wr", {22'd0, wr_addr, wr_data}, 32'd0);
        check("abort_pulses", (n_strobe - s0) + (n_done - d0) + (n_err - e0), 32'd0);
        for (int a = 0; a < 4; a++) host_read_check("abort_mem", a[1:0], 8'h00);
        spi_frame(2'd3, 24'h82C300, 16, -1, rx);
        host_read_check("post_abort_mem2", 2'd2, 8'hC3);
        check("post_abort_done", n_done - d0, 32'd1);

        // 24-bit frame: third byte ignored
        s0 = n_strobe; d0 = n_done;
        spi_frame(2'd0, 24'h8177EE, 24, -1, rx);
        host_read_check("long_mem1", 2'd1, 8'h77);
        check("long_miso_hold", {24'd0, rx[7:0]}, 32'd0);
        check("long_done", n_done - d0, 32'd1);
        check("long_strobes", n_strobe - s0, 32'd1);
        check("long_wr_data", {24'd0, wr_data}, 32'h77);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral side) paired with the existing SPI initiator. It receives SCLK/CS/MOSI from an external initiator, oversamples them in the `clk` domain, and decodes a 2-byte command/data frame. Frames read and write a 4-entry × 8-bit register file, which the host logic also accesses through a local port. Supports all four SPI modes with MSB-first transfer.

## Interface
- `DATA_WIDTH`, 8: bits per SPI byte; the register width.
- `SYNC_STAGES`, 2: number of synchronizer flops on `spi_sclk`, `spi_cs`, `spi_mosi`.
- `clk` input 1: system clock. All logic is in this domain.
- `rst` input 1: asynchronous, active-high reset.
- `spi_mode` input 2: `[1]`=CPOL, `[0]`=CPHA. Sampled on the synchronized CS falling edge and held for the frame.
- `spi_sclk` input 1: serial clock from the initiator. Asynchronous.
- `spi_cs` input 1: chip select, active low. Asynchronous.
- `spi_mosi` input 1: serial data in.
- `spi_miso` output 1: serial data out. Driven 0 while not selected.
- `host_addr` input 2: local register address.
- `host_we` input 1: local write enable.
- `host_wdata` input 8: local write data.
- `host_rdata` output 8: `mem[host_addr]`, registered, 1-cycle latency.
- `wr_strobe` output 1: 1-cycle pulse when an SPI write commits.
- `wr_addr` output 2: address of the last SPI write. Held until the next write.
- `wr_data` output 8: data of the last SPI write. Held until the next write.
- `transfer_done` output 1: 1-cycle pulse on CS rise after a complete frame (≥16 bits).
- `frame_error` output 1: 1-cycle pulse on CS rise after a short frame (<16 bits).

## Operation
- Synchronize `spi_sclk`/`spi_cs`/`spi_mosi` through `SYNC_STAGES` flops, then edge-detect.
- Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
- CPHA=0: sample MOSI on the leading edge; shift MISO on the trailing edge; the first MISO bit is valid on CS fall.
- CPHA=1: shift MISO on the leading edge; sample MOSI on the trailing edge.
- Frame format:
  - Byte 0 (command): bit7 = W (1 write, 0 read); bits1:0 = address; bits6:2 ignored.
  - Byte 1: data.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE → CMD on CS fall. Load the MISO shift register with status byte 8'hA5; bit counter = 0.
  - CMD → DATA on the 8th sample. Latch W and address. Load the MISO shift register with `mem[addr]`, snapshotted at this cycle. The first byte-1 bit shifts out on the next shift edge.
  - DATA → HOLD on the 16th sample. If W=1: commit `mem[addr]` ← received byte, pulse `wr_strobe`, and update `wr_addr`/`wr_data`.
  - HOLD: extra SCLK edges are ignored; MISO = 0.
  - Any state → IDLE on CS rise. Pulse `transfer_done` if 16 samples were taken, otherwise pulse `frame_error`. A short frame never commits a write.
- Register file:
  - The host writes `mem[host_addr]` ← `host_wdata` when `host_we`=1.
  - On a same-cycle SPI commit and host write to the same address, the SPI write wins and the host write is dropped.
  - Different addresses: both writes take effect.
- A CS fall while already selected is impossible by definition. A CS glitch shorter than the synchronizer depth may be missed; this is a permitted limitation.
- Bits beyond 16 within one CS assertion: no effect and no error.

## Timing
- Reset values:
  - `spi_miso`=0, `host_rdata`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `transfer_done`=0, `frame_error`=0.
  - All `mem`=0; FSM = IDLE; synchronizers load idle values (CS=1, SCLK=0, MOSI=0).
- Reset mid-frame aborts the frame: no commit, no pulse. After reset, the target waits for the next CS fall.
- Edge-to-effect latency: `SYNC_STAGES`+1 clk from a pin transition to a sample or MISO update.
- Interface constraint on the initiator:
  - SCLK half-period ≥ `SYNC_STAGES`+2 clk.
  - ≥ `SYNC_STAGES`+2 clk from CS fall to the first SCLK edge.
  - ≥ `SYNC_STAGES`+2 clk from the last SCLK edge to CS rise.
- `wr_strobe` asserts `SYNC_STAGES`+1 clk after the 16th sampling edge on the pins. `mem` is updated in the same cycle.
- `transfer_done`/`frame_error` assert `SYNC_STAGES`+1 clk after CS rise on the pin.
- `host_rdata` reflects a write committed in cycle N from cycle N+2 onward.

## Test plan
- Mode 0, write frame 8'h82, 8'h3C → `wr_strobe` pulses once; `wr_addr`=2, `wr_data`=8'h3C; `mem[2]`=8'h3C; MISO byte 0 reads 8'hA5; `transfer_done` pulses once.
- Modes 1/2/3: host preloads `mem[1]`=8'h5A; SPI read 8'h01, 8'h00 → initiator receives 8'hA5 then 8'h5A; no `wr_strobe`.
- Short frame: write command 8'h83 plus 5 data bits, then CS rise → `frame_error` pulses; `mem[3]` unchanged; no `transfer_done`.
- Collision: host writes `mem[0]`=8'hFF in the same cycle as an SPI commit of 8'h11 to address 0 → `mem[0]`=8'h11. Repeat with host address 1 → `mem[1]`=8'hFF and `mem[0]`=8'h11.
- Assert `rst` after bit 10 of a write frame → all outputs and `mem` return to 0. A following complete frame decodes normally.
- 24-bit frame writing 8'h81, 8'h77, 8'hEE → `mem[1]`=8'h77; third byte ignored; MISO=0 during it; `transfer_done` pulses.
